sha256_sched_ctrl: RTL

Sequencing controller for the SHA-256 message schedule and hash core. It accepts 512-bit message blocks as sixteen 32-bit words over a valid/ready handshake and forwards them to `message_shcdule` as `data`/`write_enable`. It runs the 64-round counter, drives `inner_busy` for rounds 16..63, and issues the init, round-enable and update strobes to the hash core. It also reports digest completion to the host side.

---
 rtl/sha256_sched_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sha256_sched_ctrl.sv
// SHA-256 block sequencer: word intake, 64-round counter and hash-core strobes.
// Optional `abort` input enabled by defining SHA_CTRL_ABORT_EN.
module sha256_sched_ctrl #(
    parameter int unsigned ROUNDS = 64,
    parameter int unsigned WORDS  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_first,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] ms_data,
    output logic        ms_write_enable,
    output logic        ms_inner_busy,
    output logic [5:0]  round_idx,
    output logic        core_init,
    output logic        core_round_en,
    output logic        core_update,
    output logic        digest_valid,
    input  logic        digest_ack,
`ifdef SHA_CTRL_ABORT_EN
    input  logic        abort,
`endif
    output logic        busy
);

    localparam int unsigned CW = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          last_q, last_nxt;
    logic          open_q, open_nxt;
    logic          rst_q;
    logic          accept;

    // State, round counter and message bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            last_q <= 1'b0;
            open_q <= 1'b0;
            rst_q  <= 1'b1;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            last_q <= last_nxt;
            open_q <= open_nxt;
            rst_q  <= 1'b0;
        end
    end

    // rst_q keeps in_ready low for every cycle in which reset was sampled
    assign in_ready        = !rst_q && (state == S_IDLE || state == S_LOAD);
    assign accept          = in_valid & in_ready;
    assign ms_data         = in_data;
    assign ms_write_enable = accept;
    assign ms_inner_busy   = (state == S_COMPUTE);
    assign round_idx       = cnt;
    assign digest_valid    = (state == S_DONE);
    assign busy            = (state != S_IDLE);

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        last_nxt      = last_q;
        open_nxt      = open_q;
        core_init     = 1'b0;
        core_round_en = 1'b0;
        core_update   = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    core_round_en = 1'b1;
                    // An unopened message always starts from the IV
                    core_init     = in_first | ~open_q;
                    last_nxt      = in_last;
                    open_nxt      = 1'b1;
                    cnt_nxt       = CW'(1);
                    state_nxt     = S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    core_round_en = 1'b1;
                    cnt_nxt       = cnt + CW'(1);
                    if (cnt == CW'(WORDS - 1)) begin
                        state_nxt = S_COMPUTE;
                    end
                end
            end
            S_COMPUTE: begin
                core_round_en = 1'b1;
                if (cnt == CW'(ROUNDS - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = S_UPDATE;
                end else begin
                    cnt_nxt   = cnt + CW'(1);
                end
            end
            S_UPDATE: begin
                core_update = 1'b1;
                cnt_nxt     = '0;
                if (last_q) begin
                    open_nxt  = 1'b0;
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                if (digest_ack) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase

`ifdef SHA_CTRL_ABORT_EN
        // Abort discards the block and closes the message without touching H
        if (abort) begin
            state_nxt     = S_IDLE;
            cnt_nxt       = '0;
            last_nxt      = 1'b0;
            open_nxt      = 1'b0;
            core_init     = 1'b0;
            core_round_en = 1'b0;
            core_update   = 1'b0;
        end
`endif
    end

endmodule
